// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
// Holds the ALU opcode codes, the instruction class encoding used to drive
// write enables and branching, the FSM state encoding, and the select value
// that makes the ALU idle.
package instr_sequencer_pkg;

    // ALU opcode codes (6-bit select presented to the ALU).
    localparam logic [5:0] OP_ADDA  = 6'h00;
    localparam logic [5:0] OP_ADDB  = 6'h01;
    localparam logic [5:0] OP_ADDCA = 6'h02;
    localparam logic [5:0] OP_ADDCB = 6'h03;
    localparam logic [5:0] OP_SUBA  = 6'h04;
    localparam logic [5:0] OP_SUBB  = 6'h05;
    localparam logic [5:0] OP_SUBCA = 6'h06;
    localparam logic [5:0] OP_SUBCB = 6'h07;
    localparam logic [5:0] OP_ANDA  = 6'h08;
    localparam logic [5:0] OP_ANDB  = 6'h09;
    localparam logic [5:0] OP_ANDCA = 6'h0A;
    localparam logic [5:0] OP_ANDCB = 6'h0B;
    localparam logic [5:0] OP_ORA   = 6'h0C;
    localparam logic [5:0] OP_ORB   = 6'h0D;
    localparam logic [5:0] OP_ORCA  = 6'h0E;
    localparam logic [5:0] OP_ORCB  = 6'h0F;
    localparam logic [5:0] OP_ASLA  = 6'h10;
    localparam logic [5:0] OP_ASRA  = 6'h11;
    localparam logic [5:0] OP_JMP   = 6'h18;
    localparam logic [5:0] OP_BAEQ  = 6'h19;
    localparam logic [5:0] OP_BANE  = 6'h1A;
    localparam logic [5:0] OP_BBEQ  = 6'h1B;
    localparam logic [5:0] OP_BBNE  = 6'h1C;

    // Select value that matches no ALU operation, so the ALU idles.
    localparam logic [5:0] NOP_SEL  = 6'h3F;

    typedef enum logic [1:0] {
        CLS_NOP = 2'd0,
        CLS_A   = 2'd1,
        CLS_B   = 2'd2,
        CLS_BR  = 2'd3
    } instr_class_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Program-memory fetch bus between the sequencer and the instruction ROM.
//   instr_addr  : fetch address (driven by master)
//   instr_req   : fetch request, held until instr_valid (driven by master)
//   instr_valid : instr_data is valid, completes the fetch (driven by slave)
//   instr_data  : [15:10] opcode, [9:8] ignored, [7:0] immediate/target
interface instr_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_req;
    logic              instr_valid;
    logic [15:0]       instr_data;

    modport master (
        output instr_addr,
        output instr_req,
        input  instr_valid,
        input  instr_data
    );

    modport slave (
        input  instr_addr,
        input  instr_req,
        output instr_valid,
        output instr_data
    );
endinterface

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier.
//   opcode   : 6-bit ALU select
//   cls      : CLS_A / CLS_B (accumulator written), CLS_BR (branch/JMP),
//              CLS_NOP (anything else, including unknown codes)
//   uses_imm : 1 for the *C* forms whose second operand is the immediate
module instr_class_decode
    import instr_sequencer_pkg::*;
(
    input  logic [5:0]   opcode,
    output instr_class_t cls,
    output logic         uses_imm
);

    always_comb begin
        cls = CLS_NOP;
        unique case (opcode)
            OP_ADDA, OP_ADDCA, OP_SUBA, OP_SUBCA,
            OP_ANDA, OP_ANDCA, OP_ORA,  OP_ORCA,
            OP_ASLA, OP_ASRA:                     cls = CLS_A;
            OP_ADDB, OP_ADDCB, OP_SUBB, OP_SUBCB,
            OP_ANDB, OP_ANDCB, OP_ORB,  OP_ORCB:  cls = CLS_B;
            OP_JMP,  OP_BAEQ,  OP_BANE,
            OP_BBEQ, OP_BBNE:                     cls = CLS_BR;
            default:                              cls = CLS_NOP;
        endcase
    end

    always_comb begin
        uses_imm = 1'b0;
        unique case (opcode)
            OP_ADDCA, OP_ADDCB, OP_SUBCA, OP_SUBCB,
            OP_ANDCA, OP_ANDCB, OP_ORCA,  OP_ORCB: uses_imm = 1'b1;
            default:                               uses_imm = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches one 16-bit instruction at a time over the
// req/valid fetch bus, presents the decoded opcode/immediate to the ALU,
// pulses the accumulator write enables for one cycle and picks the next PC
// from the ALU branch decision.
//   iClock, iReset_n : clock (rising edge), asynchronous active-low reset
//   mem              : fetch bus (master side)
//   oAluInstSel      : opcode presented to the ALU (6'h3F when idle)
//   oUseImm          : ALU operand 2 is oImm instead of the other accumulator
//   oImm             : latched immediate / branch target
//   oWrA, oWrB       : one-cycle accumulator load pulses (combinational)
//   iBranchTaken     : ALU branch decision for the current instruction
//   oPC              : current program counter
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              iClock,
    input  logic              iReset_n,
    instr_sequencer_if.master mem,
    output logic [5:0]        oAluInstSel,
    output logic              oUseImm,
    output logic [7:0]        oImm,
    output logic              oWrA,
    output logic              oWrB,
    input  logic              iBranchTaken,
    output logic [ADDR_W-1:0] oPC
);

    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              req_reg;
    logic [5:0]        sel_reg;
    logic [7:0]        imm_reg;
    logic              use_imm_reg;
    instr_class_t      cls_reg;

    instr_class_t      dec_cls;
    logic              dec_uses_imm;
    logic              fetch_done;
    logic              unused_bits;

    // Bits [9:8] of the instruction word carry no meaning.
    assign unused_bits = ^mem.instr_data[9:8];

    // Decode the incoming word so class and operand routing are latched
    // together with the opcode.
    instr_class_decode u_decode (
        .opcode   (mem.instr_data[15:10]),
        .cls      (dec_cls),
        .uses_imm (dec_uses_imm)
    );

    // Valid only completes a fetch while a request is actually outstanding.
    assign fetch_done = (state_reg == ST_WAIT) && req_reg && mem.instr_valid;

    // Branch target replaces PC+1 only for branch-class opcodes; for every
    // other class iBranchTaken is ignored.
    always_comb begin
        pc_next = pc_reg + ADDR_W'(1);
        if (cls_reg == CLS_BR && iBranchTaken) begin
            pc_next = ADDR_W'(imm_reg);
        end
    end

    // State register
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_FETCH: state_next = ST_WAIT;
            ST_WAIT:  state_next = fetch_done ? ST_EXEC : ST_WAIT;
            ST_EXEC:  state_next = ST_FETCH;
            default:  state_next = ST_FETCH;
        endcase
    end

    // Output logic: write enables follow the state directly so an
    // asynchronous reset cuts a pulse in the same cycle.
    always_comb begin
        oWrA = 1'b0;
        oWrB = 1'b0;
        if (state_reg == ST_EXEC) begin
            oWrA = (cls_reg == CLS_A);
            oWrB = (cls_reg == CLS_B);
        end
    end

    // Registered datapath
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            pc_reg      <= RESET_PC_V;
            addr_reg    <= RESET_PC_V;
            req_reg     <= 1'b0;
            sel_reg     <= NOP_SEL;
            imm_reg     <= 8'h00;
            use_imm_reg <= 1'b0;
            cls_reg     <= CLS_NOP;
        end else begin
            unique case (state_reg)
                ST_FETCH: begin
                    req_reg  <= 1'b1;
                    addr_reg <= pc_reg;
                end
                ST_WAIT: begin
                    if (fetch_done) begin
                        req_reg     <= 1'b0;
                        sel_reg     <= mem.instr_data[15:10];
                        imm_reg     <= mem.instr_data[7:0];
                        use_imm_reg <= dec_uses_imm;
                        cls_reg     <= dec_cls;
                    end
                end
                ST_EXEC: begin
                    pc_reg <= pc_next;
                end
                default: begin
                    req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem.instr_addr = addr_reg;
    assign mem.instr_req  = req_reg;
    assign oAluInstSel    = sel_reg;
    assign oUseImm        = use_imm_reg;
    assign oImm           = imm_reg;
    assign oPC            = pc_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer. The bench plays the program
// memory and the ALU branch output; expected values are hand-derived.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       branch_taken;
    logic [5:0] alu_sel;
    logic       use_imm;
    logic [7:0] imm;
    logic       wra;
    logic       wrb;
    logic [7:0] pc;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    instr_sequencer_if #(.ADDR_W(8)) bus ();

    instr_sequencer #(.ADDR_W(8), .RESET_PC(0)) dut (
        .iClock       (clk),
        .iReset_n     (rst_n),
        .mem          (bus.master),
        .oAluInstSel  (alu_sel),
        .oUseImm      (use_imm),
        .oImm         (imm),
        .oWrA         (wra),
        .oWrB         (wrb),
        .iBranchTaken (branch_taken),
        .oPC          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch starting from the first WAIT cycle; returns the write
    // enables seen during EXEC and the PC right after EXEC. Ends in WAIT.
    task automatic run_instr(input logic [5:0] op, input logic [7:0] im,
                             input int dly, input logic taken,
                             output logic wa, output logic wb,
                             output logic [7:0] pc_after);
        repeat (dly) tick();
        bus.instr_valid = 1'b1;
        bus.instr_data  = {op, 2'b11, im};
        branch_taken    = taken;
        tick();
        wa = wra;
        wb = wrb;
        bus.instr_valid = 1'b0;
        tick();
        branch_taken = 1'b0;
        pc_after = pc;
        $display("txn op=%h imm=%h taken=%0b wra=%0b wrb=%0b pc_after=%h",
                 op, im, taken, wa, wb, pc_after);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", pc); end
        checks++; if (bus.instr_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.instr_req); end
        checks++; if ({wra, wrb} !== 2'b00) begin errors++; $display("FAIL reset_wr got=%b exp=00", {wra, wrb}); end
        checks++; if (alu_sel !== 6'h3F) begin errors++; $display("FAIL reset_sel got=%h exp=3f", alu_sel); end
        checks++; if ({use_imm, imm} !== 9'h000) begin errors++; $display("FAIL reset_imm got=%h exp=000", {use_imm, imm}); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.instr_req !== 1'b1) begin errors++; $display("FAIL first_req got=%b exp=1", bus.instr_req); end
        checks++; if (bus.instr_addr !== 8'h00) begin errors++; $display("FAIL first_addr got=%h exp=00", bus.instr_addr); end
        $display("txn reset released, fetch at addr=%h", bus.instr_addr);
    endtask

    task automatic test_addca();
        int rise;
        rise = cyc;
        bus.instr_valid = 1'b1;
        bus.instr_data  = {OP_ADDCA, 2'b00, 8'h05};
        tick();
        bus.instr_valid = 1'b0;
        checks++; if (alu_sel !== OP_ADDCA) begin errors++; $display("FAIL addca_sel got=%h exp=%h", alu_sel, OP_ADDCA); end
        checks++; if (use_imm !== 1'b1) begin errors++; $display("FAIL addca_useimm got=%b exp=1", use_imm); end
        checks++; if (imm !== 8'h05) begin errors++; $display("FAIL addca_imm got=%h exp=05", imm); end
        checks++; if ({wra, wrb} !== 2'b10) begin errors++; $display("FAIL addca_wr_exec got=%b exp=10", {wra, wrb}); end
        checks++; if (bus.instr_req !== 1'b0) begin errors++; $display("FAIL addca_req_drop got=%b exp=0", bus.instr_req); end
        tick();
        checks++; if ({wra, wrb} !== 2'b00) begin errors++; $display("FAIL addca_wr_after got=%b exp=00", {wra, wrb}); end
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL addca_pc got=%h exp=01", pc); end
        tick();
        checks++; if (bus.instr_req !== 1'b1) begin errors++; $display("FAIL addca_next_req got=%b exp=1", bus.instr_req); end
        checks++; if (cyc - rise !== 3) begin errors++; $display("FAIL addca_req_spacing got=%0d exp=3", cyc - rise); end
        checks++; if (bus.instr_addr !== 8'h01) begin errors++; $display("FAIL addca_next_addr got=%h exp=01", bus.instr_addr); end
        $display("txn ADDCA imm=05 pc=%h", pc);
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.instr_addr !== 8'h01 || bus.instr_req !== 1'b1) begin
                errors++; $display("FAIL subb_wait%0d got addr=%h req=%b exp addr=01 req=1", i, bus.instr_addr, bus.instr_req);
            end
            checks++; if ({wra, wrb} !== 2'b00) begin errors++; $display("FAIL subb_wait_wr%0d got=%b exp=00", i, {wra, wrb}); end
        end
        bus.instr_valid = 1'b1;
        bus.instr_data  = {OP_SUBB, 2'b01, 8'h33};
        tick();
        bus.instr_valid = 1'b0;
        checks++; if ({wra, wrb} !== 2'b01) begin errors++; $display("FAIL subb_wr_exec got=%b exp=01", {wra, wrb}); end
        checks++; if (use_imm !== 1'b0) begin errors++; $display("FAIL subb_useimm got=%b exp=0", use_imm); end
        tick();
        checks++; if ({wra, wrb} !== 2'b00) begin errors++; $display("FAIL subb_wr_after got=%b exp=00", {wra, wrb}); end
        checks++; if (pc !== 8'h02) begin errors++; $display("FAIL subb_pc got=%h exp=02", pc); end
        tick();
        $display("txn SUBB delayed 4 pc=%h", pc);
    endtask

    task automatic test_branch();
        logic wa, wb;
        logic [7:0] p;
        run_instr(OP_BAEQ, 8'h40, 0, 1'b1, wa, wb, p);
        checks++; if (p !== 8'h40) begin errors++; $display("FAIL baeq_taken_pc got=%h exp=40", p); end
        checks++; if ({wa, wb} !== 2'b00) begin errors++; $display("FAIL baeq_wr got=%b exp=00", {wa, wb}); end
        run_instr(OP_BAEQ, 8'h77, 0, 1'b0, wa, wb, p);
        checks++; if (p !== 8'h41) begin errors++; $display("FAIL baeq_not_taken_pc got=%h exp=41", p); end
        run_instr(OP_JMP, 8'h10, 1, 1'b1, wa, wb, p);
        checks++; if (p !== 8'h10) begin errors++; $display("FAIL jmp_pc got=%h exp=10", p); end
        checks++; if (bus.instr_addr !== 8'h10) begin errors++; $display("FAIL jmp_fetch_addr got=%h exp=10", bus.instr_addr); end
    endtask

    task automatic test_wrap_and_nop();
        logic wa, wb;
        logic [7:0] p;
        run_instr(OP_JMP, 8'hFF, 0, 1'b1, wa, wb, p);
        checks++; if (p !== 8'hFF) begin errors++; $display("FAIL jmp_ff_pc got=%h exp=ff", p); end
        run_instr(OP_ORA, 8'h00, 0, 1'b0, wa, wb, p);
        checks++; if (p !== 8'h00) begin errors++; $display("FAIL wrap_pc got=%h exp=00", p); end
        checks++; if ({wa, wb} !== 2'b10) begin errors++; $display("FAIL ora_wr got=%b exp=10", {wa, wb}); end
        run_instr(6'h3E, 8'h55, 0, 1'b0, wa, wb, p);
        checks++; if (p !== 8'h01) begin errors++; $display("FAIL unknown_pc got=%h exp=01", p); end
        checks++; if ({wa, wb} !== 2'b00) begin errors++; $display("FAIL unknown_wr got=%b exp=00", {wa, wb}); end
        run_instr(OP_ANDA, 8'h80, 0, 1'b1, wa, wb, p);
        checks++; if (p !== 8'h02) begin errors++; $display("FAIL anda_taken_pc got=%h exp=02", p); end
        checks++; if ({wa, wb} !== 2'b10) begin errors++; $display("FAIL anda_wr got=%b exp=10", {wa, wb}); end
    endtask

    task automatic test_reset_in_exec();
        bus.instr_valid = 1'b1;
        bus.instr_data  = {OP_ADDA, 2'b00, 8'h12};
        tick();
        bus.instr_valid = 1'b0;
        checks++; if (wra !== 1'b1) begin errors++; $display("FAIL adda_exec_wra got=%b exp=1", wra); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wra !== 1'b0) begin errors++; $display("FAIL async_cut_wra got=%b exp=0", wra); end
        checks++; if (pc !== 8'h00 || alu_sel !== 6'h3F) begin
            errors++; $display("FAIL async_reset_state got pc=%h sel=%h exp pc=00 sel=3f", pc, alu_sel);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (bus.instr_req !== 1'b1 || bus.instr_addr !== 8'h00) begin
            errors++; $display("FAIL restart_fetch got req=%b addr=%h exp req=1 addr=00", bus.instr_req, bus.instr_addr);
        end
        $display("txn reset during EXEC, refetch addr=%h", bus.instr_addr);
    endtask

    initial begin
        rst_n           = 1'b0;
        branch_taken    = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_data  = 16'h0000;
        test_reset();
        test_addca();
        test_wait_states();
        test_branch();
        test_wrap_and_nop();
        test_reset_in_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
